mem_access_unit: RTL and testbench

//  Memory stage that consumes the ALU stage result: ALU_out is the byte address and RF_B the store data.

---
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage that turns one lw/sw/lb/sb request into
// req/ack transactions on a word-wide data-memory port.
// Byte stores are performed as read-modify-write.
module mem_access_unit #(
  parameter int unsigned BASE_OFFSET = 1024,
  parameter int          MEM_AW      = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req_valid,
  output logic              Req_ready,
  input  logic [31:0]       ALU_MEM_Addr,
  input  logic [31:0]       MEM_DataIn,
  input  logic              MEM_WrEn,
  input  logic              ByteOp,
  output logic [31:0]       MEM_DataOut,
  output logic              Resp_valid,
  output logic              Misaligned,
  output logic              MM_Req,
  output logic              MM_WrEn,
  output logic [MEM_AW-1:0] MM_Addr,
  output logic [31:0]       MM_WrData,
  input  logic [31:0]       MM_RdData,
  input  logic              MM_Ack
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t              r_state;
  logic                r_reqReady;
  logic                r_respValid;
  logic                r_misaligned;
  logic                r_mmReq;
  logic                r_mmWrEn;
  logic [MEM_AW-1:0]   r_mmAddr;
  logic [31:0]         r_mmWrData;
  logic [31:0]         r_dataOut;
  logic [1:0]          r_lane;
  logic [7:0]          r_storeByte;
  logic                r_isStore;
  logic                r_isByte;

  logic [31:0]         w_addr;
  logic                w_misaligned;
  logic [7:0]          w_rdLane;
  logic [31:0]         w_merged;

  // Offset byte address; the addition wraps modulo 2^32 and the word slice wraps the memory.
  assign w_addr       = ALU_MEM_Addr + 32'(BASE_OFFSET);
  assign w_misaligned = !ByteOp && (w_addr[1:0] != 2'b00);

  // Pick the addressed byte lane of the read word and build the sb merge word (little-endian lanes).
  always_comb begin
    w_rdLane = MM_RdData[7:0];
    w_merged = MM_RdData;
    case (r_lane)
      2'd0: begin
        w_rdLane       = MM_RdData[7:0];
        w_merged[7:0]  = r_storeByte;
      end
      2'd1: begin
        w_rdLane       = MM_RdData[15:8];
        w_merged[15:8] = r_storeByte;
      end
      2'd2: begin
        w_rdLane        = MM_RdData[23:16];
        w_merged[23:16] = r_storeByte;
      end
      default: begin
        w_rdLane        = MM_RdData[31:24];
        w_merged[31:24] = r_storeByte;
      end
    endcase
  end

  // Single FSM: accept a request in IDLE, run read and/or write phases, pulse the response.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_reqReady   <= 1'b1;
      r_respValid  <= 1'b0;
      r_misaligned <= 1'b0;
      r_mmReq      <= 1'b0;
      r_mmWrEn     <= 1'b0;
      r_mmAddr     <= '0;
      r_mmWrData   <= '0;
      r_dataOut    <= '0;
      r_lane       <= '0;
      r_storeByte  <= '0;
      r_isStore    <= 1'b0;
      r_isByte     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Req_valid) begin
            r_reqReady  <= 1'b0;
            r_lane      <= w_addr[1:0];
            r_storeByte <= MEM_DataIn[7:0];
            r_isStore   <= MEM_WrEn;
            r_isByte    <= ByteOp;
            r_mmAddr    <= w_addr[MEM_AW+1:2];
            if (w_misaligned) begin
              r_state      <= RESP;
              r_respValid  <= 1'b1;
              r_misaligned <= 1'b1;
            end else if (MEM_WrEn && !ByteOp) begin
              r_state    <= WR;
              r_mmReq    <= 1'b1;
              r_mmWrEn   <= 1'b1;
              r_mmWrData <= MEM_DataIn;
            end else begin
              r_state  <= RD;
              r_mmReq  <= 1'b1;
              r_mmWrEn <= 1'b0;
            end
          end
        end
        RD: begin
          if (MM_Ack) begin
            if (r_isStore) begin
              r_state    <= WR;
              r_mmWrEn   <= 1'b1;
              r_mmWrData <= w_merged;
            end else begin
              r_state     <= RESP;
              r_mmReq     <= 1'b0;
              r_respValid <= 1'b1;
              r_dataOut   <= r_isByte ? {24'b0, w_rdLane} : MM_RdData;
            end
          end
        end
        WR: begin
          if (MM_Ack) begin
            r_state     <= RESP;
            r_mmReq     <= 1'b0;
            r_mmWrEn    <= 1'b0;
            r_respValid <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_respValid  <= 1'b0;
          r_misaligned <= 1'b0;
          r_reqReady   <= 1'b1;
        end
      endcase
    end
  end

  assign Req_ready   = r_reqReady;
  assign Resp_valid  = r_respValid;
  assign Misaligned  = r_misaligned;
  assign MM_Req      = r_mmReq;
  assign MM_WrEn     = r_mmWrEn;
  assign MM_Addr     = r_mmAddr;
  assign MM_WrData   = r_mmWrData;
  assign MEM_DataOut = r_dataOut;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a behavioural
// word memory that acknowledges after a programmable number of wait cycles.
module tb_mem_access_unit;

  logic        Clk;
  logic        Reset;
  logic        Req_valid;
  logic        Req_ready;
  logic [31:0] ALU_MEM_Addr;
  logic [31:0] MEM_DataIn;
  logic        MEM_WrEn;
  logic        ByteOp;
  logic [31:0] MEM_DataOut;
  logic        Resp_valid;
  logic        Misaligned;
  logic        MM_Req;
  logic        MM_WrEn;
  logic [9:0]  MM_Addr;
  logic [31:0] MM_WrData;
  logic [31:0] MM_RdData;
  logic        MM_Ack;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        mis;
    int          acceptCyc;
    int          lat;
  } exp_t;

  exp_t        sbQueue[$];
  logic [31:0] mem [0:1023];
  int          ackDelay;
  int          waitCnt;
  int          cycleCnt;
  int          reqCycles;
  int          checkCount;
  int          passCount;

  mem_access_unit #(.BASE_OFFSET(1024), .MEM_AW(10)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Req_valid    (Req_valid),
    .Req_ready    (Req_ready),
    .ALU_MEM_Addr (ALU_MEM_Addr),
    .MEM_DataIn   (MEM_DataIn),
    .MEM_WrEn     (MEM_WrEn),
    .ByteOp       (ByteOp),
    .MEM_DataOut  (MEM_DataOut),
    .Resp_valid   (Resp_valid),
    .Misaligned   (Misaligned),
    .MM_Req       (MM_Req),
    .MM_WrEn      (MM_WrEn),
    .MM_Addr      (MM_Addr),
    .MM_WrData    (MM_WrData),
    .MM_RdData    (MM_RdData),
    .MM_Ack       (MM_Ack)
  );

  // Free-running clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Cycle counter used to measure accept-to-response latency
  always @(posedge Clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Memory model: acks after ackDelay wait cycles, writes commit on the ack cycle
  initial begin
    MM_Ack    = 1'b0;
    MM_RdData = '0;
    waitCnt   = 0;
    forever begin
      @(negedge Clk);
      if (MM_Req && !Reset) begin
        if (waitCnt >= ackDelay) begin
          MM_Ack  = 1'b1;
          waitCnt = 0;
          if (MM_WrEn) mem[MM_Addr] = MM_WrData;
          else         MM_RdData = mem[MM_Addr];
        end else begin
          MM_Ack = 1'b0;
          waitCnt++;
        end
      end else begin
        MM_Ack  = 1'b0;
        waitCnt = 0;
      end
    end
  end

  // Monitor: pop the scoreboard on every response and compare data, flag and latency
  always @(negedge Clk) begin
    if (MM_Req) reqCycles <= reqCycles + 1;
    if (!Reset && Resp_valid) begin
      if (sbQueue.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_resp: got Resp_valid=1 at cycle %0d, expected no response", cycleCnt);
      end else begin
        exp_t e;
        e = sbQueue.pop_front();
        checkOutput({e.name, " data"}, MEM_DataOut, e.data);
        checkOutput({e.name, " misaligned"}, {31'b0, Misaligned}, {31'b0, e.mis});
        checkOutput({e.name, " latency"}, 32'(cycleCnt - e.acceptCyc + 2), 32'(e.lat));
      end
    end
  end

  // Issue one request, push its expected response, check the first memory cycle and optional hold
  task automatic applyStimulus(input string name, input logic [31:0] addr, input logic [31:0] data,
                               input bit wr, input bit byteOp, input logic [31:0] expData,
                               input bit expMis, input int expLat, input logic [9:0] expMmAddr,
                               input bit expFirstWrEn, input bit checkHold);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge Clk);
    while (!Req_ready && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    if (!Req_ready) begin
      checkCount++;
      $display("[TB] FAIL %s ready_timeout: got Req_ready=0, expected 1", name);
    end
    ALU_MEM_Addr = addr;
    MEM_DataIn   = data;
    MEM_WrEn     = wr;
    ByteOp       = byteOp;
    Req_valid    = 1'b1;
    @(posedge Clk);
    #1;
    Req_valid   = 1'b0;
    e.name      = name;
    e.data      = expData;
    e.mis       = expMis;
    e.acceptCyc = cycleCnt;
    e.lat       = expLat;
    sbQueue.push_back(e);
    @(negedge Clk);
    checkOutput({name, " mm_req"}, {31'b0, MM_Req}, {31'b0, !expMis});
    checkOutput({name, " req_ready"}, {31'b0, Req_ready}, 32'd0);
    if (!expMis) begin
      checkOutput({name, " mm_addr"}, {22'b0, MM_Addr}, {22'b0, expMmAddr});
      checkOutput({name, " mm_wren"}, {31'b0, MM_WrEn}, {31'b0, expFirstWrEn});
    end
    guard = 0;
    while (sbQueue.size() != 0 && guard < 60) begin
      if (checkHold && MM_Req) begin
        checkOutput({name, " hold_addr"}, {22'b0, MM_Addr}, {22'b0, expMmAddr});
        checkOutput({name, " hold_wren"}, {31'b0, MM_WrEn}, 32'd1);
        checkOutput({name, " hold_data"}, MM_WrData, data);
        checkOutput({name, " hold_ready"}, {31'b0, Req_ready}, 32'd0);
      end
      @(negedge Clk);
      guard++;
    end
    if (sbQueue.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL %s resp_timeout: got no Resp_valid, expected one within 60 cycles", name);
      sbQueue.delete();
    end
  endtask

  // Main directed sequence
  initial begin
    int reqBefore;
    checkCount   = 0;
    passCount    = 0;
    cycleCnt     = 0;
    reqCycles    = 0;
    ackDelay     = 0;
    Reset        = 1'b1;
    Req_valid    = 1'b0;
    ALU_MEM_Addr = '0;
    MEM_DataIn   = '0;
    MEM_WrEn     = 1'b0;
    ByteOp       = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h102] = 32'hDEADBEEF;
    mem[10'h101] = 32'h11223344;
    mem[10'h000] = 32'h0BADF00D;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checkOutput("reset req_ready", {31'b0, Req_ready}, 32'd1);
    checkOutput("reset resp_valid", {31'b0, Resp_valid}, 32'd0);
    checkOutput("reset misaligned", {31'b0, Misaligned}, 32'd0);
    checkOutput("reset mm_req", {31'b0, MM_Req}, 32'd0);
    checkOutput("reset mm_wren", {31'b0, MM_WrEn}, 32'd0);
    checkOutput("reset dataout", MEM_DataOut, 32'd0);
    checkOutput("reset mm_addr", {22'b0, MM_Addr}, 32'd0);
    checkOutput("reset mm_wrdata", MM_WrData, 32'd0);
    Reset = 1'b0;

    applyStimulus("lw_0x8", 32'h8, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 3, 10'h102, 1'b0, 1'b0);
    applyStimulus("sb_0x5", 32'h5, 32'h000000AA, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 4, 10'h101, 1'b0, 1'b0);
    checkOutput("sb_0x5 mem", mem[10'h101], 32'h1122AA44);

    mem[10'h101] = 32'h80FF0011;
    applyStimulus("lb_0x7", 32'h7, 32'h0, 1'b0, 1'b1, 32'h00000080, 1'b0, 3, 10'h101, 1'b0, 1'b0);

    reqBefore = reqCycles;
    applyStimulus("sw_misaligned", 32'h6, 32'hCAFEF00D, 1'b1, 1'b0, 32'h00000080, 1'b1, 2, 10'h101, 1'b1, 1'b0);
    checkOutput("sw_misaligned mem", mem[10'h101], 32'h80FF0011);
    checkOutput("sw_misaligned no_req", 32'(reqCycles - reqBefore), 32'd0);

    ackDelay = 4;
    applyStimulus("sw_delay4", 32'h0, 32'h12345678, 1'b1, 1'b0, 32'h00000080, 1'b0, 7, 10'h100, 1'b1, 1'b1);
    checkOutput("sw_delay4 mem", mem[10'h100], 32'h12345678);

    ackDelay = 0;
    applyStimulus("lb_lane0", 32'h0, 32'h0, 1'b0, 1'b1, 32'h00000078, 1'b0, 3, 10'h100, 1'b0, 1'b0);
    applyStimulus("lw_wrap", 32'hC00, 32'h0, 1'b0, 1'b0, 32'h0BADF00D, 1'b0, 3, 10'h000, 1'b0, 1'b0);

    ackDelay = 2;
    applyStimulus("sb_delay2", 32'h2, 32'hFFFFFF55, 1'b1, 1'b1, 32'h0BADF00D, 1'b0, 8, 10'h100, 1'b0, 1'b0);
    checkOutput("sb_delay2 mem", mem[10'h100], 32'h12555678);

    ackDelay = 100;
    @(negedge Clk);
    ALU_MEM_Addr = 32'h10;
    MEM_WrEn     = 1'b0;
    ByteOp       = 1'b0;
    Req_valid    = 1'b1;
    @(posedge Clk);
    #1;
    Req_valid = 1'b0;
    @(negedge Clk);
    checkOutput("abort mm_req_before", {31'b0, MM_Req}, 32'd1);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("abort mm_req", {31'b0, MM_Req}, 32'd0);
    checkOutput("abort req_ready", {31'b0, Req_ready}, 32'd1);
    checkOutput("abort resp_valid", {31'b0, Resp_valid}, 32'd0);
    checkOutput("abort dataout", MEM_DataOut, 32'd0);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    ackDelay = 0;

    applyStimulus("lw_after_abort", 32'h8, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 3, 10'h102, 1'b0, 1'b0);

    repeat (3) @(negedge Clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
